// File: rtl/alu_exec_unit_if.sv
// Request/response handshake bundle for alu_exec_unit: operation request in, flagged result out.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             br_taken;
  logic             op_err;

  modport master (
    output in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, br_taken, op_err
  );

  modport slave (
    input  in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, br_taken, op_err
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes and a bit-serial shifter.
// Define ALU_BARREL_SHIFT_EN to replace the serial shifter with single-cycle barrel shifts.
module alu_exec_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  alu_exec_unit_if.slave bus
);
  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpSll  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpBeq  = 4'b1000;
  localparam logic [3:0] OpBne  = 4'b1001;
  localparam logic [3:0] OpBlt  = 4'b1010;
  localparam logic [3:0] OpBge  = 4'b1011;
  localparam logic [3:0] OpSlt  = 4'b1100;
  localparam logic [3:0] OpSltu = 4'b1110;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             br_q, br_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] a, b, diff, alu_res;
  logic [SHAMT_W-1:0] shamt;
  logic             alu_br, alu_err, lt_s, lt_u;

  assign a     = bus.src_a;
  assign b     = bus.src_b;
  assign shamt = b[SHAMT_W-1:0];
  assign diff  = a - b;
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  // Single-cycle evaluation; in the serial build shifts yield A here and finish in StShift.
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    alu_err = 1'b0;
    case (bus.op)
      OpAnd:  alu_res = a & b;
      OpOr:   alu_res = a | b;
      OpAdd:  alu_res = a + b;
      OpXor:  alu_res = a ^ b;
      OpSub:  alu_res = diff;
`ifdef ALU_BARREL_SHIFT_EN
      OpSll:  alu_res = a << shamt;
      OpSrl:  alu_res = a >> shamt;
      OpSra:  alu_res = WIDTH'($signed(a) >>> shamt);
`else
      OpSll, OpSrl, OpSra: alu_res = a;
`endif
      OpSlt:  alu_res = WIDTH'(lt_s);
      OpSltu: alu_res = WIDTH'(lt_u);
      OpBeq: begin alu_res = diff; alu_br = (a == b); end
      OpBne: begin alu_res = diff; alu_br = (a != b); end
      OpBlt: begin alu_res = diff; alu_br = lt_s;     end
      OpBge: begin alu_res = diff; alu_br = !lt_s;    end
      default: alu_err = 1'b1;
    endcase
  end

`ifndef ALU_BARREL_SHIFT_EN
  logic [3:0]         op_q, op_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   shift_nxt;
  logic               is_shift;

  assign is_shift = (bus.op == OpSll) || (bus.op == OpSrl) || (bus.op == OpSra);

  // result_q doubles as the shift working register.
  always_comb begin
    case (op_q)
      OpSll:   shift_nxt = result_q << 1;
      OpSrl:   shift_nxt = result_q >> 1;
      default: shift_nxt = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_q    <= 4'b0000;
      count_q <= '0;
    end else begin
      op_q    <= op_d;
      count_q <= count_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    br_d     = br_q;
    err_d    = err_q;
`ifndef ALU_BARREL_SHIFT_EN
    op_d     = op_q;
    count_d  = count_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          result_d = alu_res;
          zero_d   = (alu_res == '0);
          br_d     = alu_br;
          err_d    = alu_err;
          state_d  = StDone;
`ifndef ALU_BARREL_SHIFT_EN
          op_d     = bus.op;
          if (is_shift && (shamt != '0)) begin
            count_d = shamt;
            state_d = StShift;
          end
`endif
        end
      end
`ifndef ALU_BARREL_SHIFT_EN
      StShift: begin
        result_d = shift_nxt;
        zero_d   = (shift_nxt == '0);
        count_d  = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) state_d = StDone;
      end
`endif
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b0;
      br_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      br_q     <= br_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.br_taken  = br_q;
  assign bus.op_err    = err_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; expected values are hand-computed constants.
module tb_alu_exec_unit;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    string       tag;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        br;
    logic        err;
    int          slat;
  } vec_t;

  vec_t vecs[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic z,
                         input logic br, input logic err, input int slat);
    vec_t v;
    v.tag = tag; v.op = op; v.a = a; v.b = b; v.res = res;
    v.z = z; v.br = br; v.err = err; v.slat = slat;
    vecs.push_back(v);
  endtask

  // Presents one request, returns cycles from the accept edge until out_valid (bounded).
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    check_eq({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.in_valid = 1'b1;
    @(posedge clk_i); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      check_eq({tag, "_busy_ready"}, {31'b0, bus.in_ready}, 32'd0);
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk_i); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int exp_lat;
    bool_seen: begin end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 4'b0; bus.src_a = '0; bus.src_b = '0;

    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check_eq("rst_result", bus.result, 32'd0);
    check_eq("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check_eq("rst_flags", {29'b0, bus.zero, bus.br_taken, bus.op_err}, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    //      tag       op       a             b             result        z     br    err   serial lat
    add_vec("add",  4'b0010, 32'hFFFF_FFFF, 32'h1,       32'h0,        1'b1, 1'b0, 1'b0, 1);
    add_vec("sub",  4'b0110, 32'd5,        32'd7,        32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1);
    add_vec("and",  4'b0000, 32'hF0F0,     32'h0FF0,     32'h00F0,     1'b0, 1'b0, 1'b0, 1);
    add_vec("or",   4'b0001, 32'hF0F0,     32'h0FF0,     32'hFFF0,     1'b0, 1'b0, 1'b0, 1);
    add_vec("sra4", 4'b0111, 32'h8000_0000, 32'd4,       32'hF800_0000, 1'b0, 1'b0, 1'b0, 5);
    add_vec("sll0", 4'b0100, 32'd1,        32'd0,        32'd1,        1'b0, 1'b0, 1'b0, 1);
    add_vec("sll31",4'b0100, 32'd1,        32'd31,       32'h8000_0000, 1'b0, 1'b0, 1'b0, 32);
    add_vec("srl3", 4'b0101, 32'h8000_0000, 32'h0000_0023, 32'h1000_0000, 1'b0, 1'b0, 1'b0, 4);
    add_vec("sra1", 4'b0111, 32'h8000_0001, 32'h21,      32'hC000_0000, 1'b0, 1'b0, 1'b0, 2);
    add_vec("blt",  4'b1010, 32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1);
    add_vec("bge",  4'b1011, 32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1);
    add_vec("beq",  4'b1000, 32'd9,        32'd9,        32'd0,        1'b1, 1'b1, 1'b0, 1);
    add_vec("bne",  4'b1001, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0, 1'b0, 1);
    add_vec("sltu", 4'b1110, 32'hFFFF_FFFF, 32'd1,       32'd0,        1'b1, 1'b0, 1'b0, 1);
    add_vec("slt",  4'b1100, 32'hFFFF_FFFF, 32'd1,       32'd1,        1'b0, 1'b0, 1'b0, 1);
    add_vec("undef",4'b1111, 32'd3,        32'd4,        32'd0,        1'b1, 1'b0, 1'b1, 1);
    add_vec("und13",4'b1101, 32'd3,        32'd4,        32'd0,        1'b1, 1'b0, 1'b1, 1);

    foreach (vecs[i]) begin
`ifdef ALU_BARREL_SHIFT_EN
      exp_lat = 1;
`else
      exp_lat = vecs[i].slat;
`endif
      issue(vecs[i].tag, vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check_eq({vecs[i].tag, "_latency"}, lat, exp_lat);
      check_eq({vecs[i].tag, "_result"}, bus.result, vecs[i].res);
      check_eq({vecs[i].tag, "_flags"}, {29'b0, bus.zero, bus.br_taken, bus.op_err},
               {29'b0, vecs[i].z, vecs[i].br, vecs[i].err});
      retire();
      check_eq({vecs[i].tag, "_drop"}, {31'b0, bus.out_valid}, 32'd0);
    end

    // Backpressure: result held, new requests ignored.
    issue("bp", 4'b0011, 32'hF0F0, 32'h0FF0, lat);
    check_eq("bp_latency", lat, 1);
    for (int c = 0; c < 4; c++) begin
      bus.op = 4'b0010; bus.src_a = 32'd1; bus.src_b = 32'd1; bus.in_valid = c[0];
      @(posedge clk_i); #1;
      check_eq("bp_result", bus.result, 32'hFF00);
      check_eq("bp_valid", {31'b0, bus.out_valid}, 32'd1);
      check_eq("bp_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    retire();
    repeat (3) begin
      check_eq("bp_no_queue", {31'b0, bus.out_valid}, 32'd0);
      @(posedge clk_i); #1;
    end

    // Reset while the long shift is in flight: no result may ever appear.
    bus.op = 4'b0100; bus.src_a = 32'd1; bus.src_b = 32'd31; bus.in_valid = 1'b1;
    @(posedge clk_i); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    check_eq("mid_rst_ready", {31'b0, bus.in_ready}, 32'd1);
    check_eq("mid_rst_result", bus.result, 32'd0);
    lat = 0;
    repeat (40) begin
      if (bus.out_valid) lat++;
      @(posedge clk_i); #1;
    end
    check_eq("mid_rst_no_valid", lat, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
